// File: rtl/ex_mem_reg_pkg.sv
// ============================================================================
// Module   : ex_mem_reg_pkg
// Purpose  : Shared widths, stage-action encoding and the stall/flush decode
//            for the EX/MEM pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mem_reg_pkg;

  localparam int c_DATA_W = 32;  // RegBus
  localparam int c_ADDR_W = 5;   // RegAddrBus
  localparam int c_CNT_W  = 2;   // CntBus

  typedef enum logic [1:0] {
    ACT_PASS   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } stage_act_e;

  // A stalled MEM stage freezes the register even when EX is not stalled,
  // so the never-expected stall_ex=0/stall_mem=1 combination degrades to HOLD.
  function automatic stage_act_e decode_act(input logic flush,
                                            input logic stall_ex,
                                            input logic stall_mem);
    if (flush)     return ACT_FLUSH;
    if (stall_mem) return ACT_HOLD;
    if (stall_ex)  return ACT_BUBBLE;
    return ACT_PASS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_reg_if.sv
// ============================================================================
// Module   : ex_mem_if
// Purpose  : EX -> MEM bundle: stall/flush control, execute results, the
//            registered MEM-side view and the parked multi-cycle state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_mem_if
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W,
  parameter int CNT_W  = c_CNT_W
);

  logic                stall_ex;
  logic                stall_mem;
  logic                flush;

  logic [DATA_W-1:0]   ex_wdata;
  logic [ADDR_W-1:0]   ex_waddr;
  logic                ex_wr_en;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic                ex_hilo_en;
  logic [2*DATA_W-1:0] hilo_temp_i;
  logic [CNT_W-1:0]    cnt_i;

  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   mem_waddr;
  logic                mem_wr_en;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_hilo_en;
  logic                mem_valid;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [CNT_W-1:0]    cnt_o;

  // Driver side: execute stage plus stall control.
  modport master (
    output stall_ex, stall_mem, flush,
    output ex_wdata, ex_waddr, ex_wr_en, ex_hi, ex_lo, ex_hilo_en,
    output hilo_temp_i, cnt_i,
    input  mem_wdata, mem_waddr, mem_wr_en, mem_hi, mem_lo, mem_hilo_en,
    input  mem_valid, hilo_temp_o, cnt_o
  );

  // Register side.
  modport slave (
    input  stall_ex, stall_mem, flush,
    input  ex_wdata, ex_waddr, ex_wr_en, ex_hi, ex_lo, ex_hilo_en,
    input  hilo_temp_i, cnt_i,
    output mem_wdata, mem_waddr, mem_wr_en, mem_hi, mem_lo, mem_hilo_en,
    output mem_valid, hilo_temp_o, cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/ex_mem_reg.sv
// ============================================================================
// Module   : ex_mem_reg
// Purpose  : EX/MEM pipeline register with stall/flush bubbles and parking of
//            the MADD/MSUB partial product across a stalled execute cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W,
  parameter int CNT_W  = c_CNT_W
) (
  input  wire logic clk,
  input  wire logic rst,
  ex_mem_if.slave   bus
);

  stage_act_e w_act;

  logic [DATA_W-1:0]   wdata_d,   wdata_q;
  logic [ADDR_W-1:0]   waddr_d,   waddr_q;
  logic                wr_en_d,   wr_en_q;
  logic [DATA_W-1:0]   hi_d,      hi_q;
  logic [DATA_W-1:0]   lo_d,      lo_q;
  logic                hilo_en_d, hilo_en_q;
  logic                valid_d,   valid_q;
  logic [2*DATA_W-1:0] temp_d,    temp_q;
  logic [CNT_W-1:0]    cnt_d,     cnt_q;

  assign w_act = decode_act(bus.flush, bus.stall_ex, bus.stall_mem);

  // Result fields: bubbles clear the write enables so nothing is committed.
  always_comb begin
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    wr_en_d   = wr_en_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hilo_en_d = hilo_en_q;
    valid_d   = valid_q;
    unique case (w_act)
      ACT_FLUSH, ACT_BUBBLE: begin
        wdata_d   = '0;
        waddr_d   = '0;
        wr_en_d   = 1'b0;
        hi_d      = '0;
        lo_d      = '0;
        hilo_en_d = 1'b0;
        valid_d   = 1'b0;
      end
      ACT_PASS: begin
        wdata_d   = bus.ex_wdata;
        waddr_d   = bus.ex_waddr;
        wr_en_d   = bus.ex_wr_en;
        hi_d      = bus.ex_hi;
        lo_d      = bus.ex_lo;
        hilo_en_d = bus.ex_hilo_en;
        valid_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q   <= '0;
      waddr_q   <= '0;
      wr_en_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      hilo_en_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      wr_en_q   <= wr_en_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hilo_en_q <= hilo_en_d;
      valid_q   <= valid_d;
    end
  end

  // Parked state is captured only while execute stalls alone; a completed
  // or killed instruction clears it so the next MADD starts from step 0.
  always_comb begin
    temp_d = temp_q;
    cnt_d  = cnt_q;
    unique case (w_act)
      ACT_FLUSH, ACT_PASS: begin
        temp_d = '0;
        cnt_d  = '0;
      end
      ACT_BUBBLE: begin
        temp_d = bus.hilo_temp_i;
        cnt_d  = bus.cnt_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      temp_q <= '0;
      cnt_q  <= '0;
    end else begin
      temp_q <= temp_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_waddr   = waddr_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_hi      = hi_q;
  assign bus.mem_lo      = lo_q;
  assign bus.mem_hilo_en = hilo_en_q;
  assign bus.mem_valid   = valid_q;
  assign bus.hilo_temp_o = temp_q;
  assign bus.cnt_o       = cnt_q;

endmodule

`default_nettype wire
